// File: rtl/o_writeback_ctrl.sv
// Output-side controller: captures the PE-array result on a ready edge, writes it row by row
// into O_buff, and on request streams O_buff words out through a 2-entry skid FIFO.
module o_writeback_ctrl #(
    parameter int DATA_WIDTH      = 16,
    parameter int NUM_PEs_PER_ROW = 4,
    parameter int NUM_ROWS        = 4,
    parameter int O_BUFF_DEPTH    = 64,
    parameter int O_ADDR_WIDTH    = 6
) (
    input  logic                                               clk,
    input  logic                                               rst,
    input  logic [NUM_ROWS*NUM_PEs_PER_ROW*DATA_WIDTH-1:0]     pe_result_i,
    input  logic                                               pe_ready_i,
    input  logic [O_ADDR_WIDTH-1:0]                            wb_base_i,
    output logic                                               wb_done_o,
    input  logic                                               rd_start_i,
    input  logic [O_ADDR_WIDTH-1:0]                            rd_base_i,
    input  logic [O_ADDR_WIDTH:0]                              rd_len_i,
    output logic                                               busy_o,
    output logic                                               o_en_o,
    output logic                                               o_wr_o,
    output logic [O_ADDR_WIDTH-1:0]                            o_addr_o,
    output logic [NUM_PEs_PER_ROW*DATA_WIDTH-1:0]              o_wdata_o,
    input  logic [NUM_PEs_PER_ROW*DATA_WIDTH-1:0]              o_rdata_i,
    output logic [NUM_PEs_PER_ROW*DATA_WIDTH-1:0]              m_data_o,
    output logic                                               m_valid_o,
    input  logic                                               m_ready_i,
    output logic                                               m_last_o
);

    localparam int W     = NUM_PEs_PER_ROW * DATA_WIDTH;
    localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int LEN_W = O_ADDR_WIDTH + 1;
    localparam logic [O_ADDR_WIDTH+1:0] DEPTH_L = (O_ADDR_WIDTH+2)'(O_BUFF_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_WRITE,
        S_WB_DONE,
        S_RD_RUN,
        S_RD_DRAIN
    } state_t;

    state_t                  r_state;
    state_t                  w_next;

    logic                    r_ready_d;
    logic [O_ADDR_WIDTH-1:0] r_wb_base;
    logic [ROW_W-1:0]        r_row;
    logic [W-1:0]            r_rows [NUM_ROWS];

    logic [O_ADDR_WIDTH-1:0] r_rd_base;
    logic [LEN_W-1:0]        r_len;
    logic [LEN_W-1:0]        r_issued;
    logic [LEN_W-1:0]        r_popped;
    logic                    r_inflight;

    logic [W-1:0]            r_fifo [2];
    logic [1:0]              r_count;
    logic                    r_wptr;
    logic                    r_rptr;

    logic                    w_ready_edge;
    logic                    w_capture;
    logic                    w_rd_accept;
    logic                    w_valid;
    logic                    w_pop;
    logic                    w_last_word;
    logic [2:0]              w_occ;
    logic                    w_issue;

    // Address of (base + off) modulo the buffer depth; off may exceed the depth by less than twice.
    function automatic logic [O_ADDR_WIDTH-1:0] wrap_addr(input logic [O_ADDR_WIDTH-1:0] base,
                                                          input logic [LEN_W-1:0]        off);
        logic [O_ADDR_WIDTH+1:0] sum;
        sum = {2'b00, base} + {1'b0, off};
        if (sum >= DEPTH_L) sum = sum - DEPTH_L;
        if (sum >= DEPTH_L) sum = sum - DEPTH_L;
        return sum[O_ADDR_WIDTH-1:0];
    endfunction

    assign w_ready_edge = pe_ready_i & ~r_ready_d;
    assign w_capture    = (r_state == S_IDLE) & w_ready_edge;
    assign w_rd_accept  = (r_state == S_IDLE) & ~w_ready_edge & rd_start_i;

    assign w_valid      = (r_count != 2'd0);
    assign w_pop        = w_valid & m_ready_i;
    assign w_last_word  = (r_popped == (r_len - LEN_W'(1)));

    // Occupancy counts the slot freed by this cycle's pop, so a steady stream sustains 1 word/cycle.
    assign w_occ   = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue = (r_state == S_RD_RUN) & (r_issued < r_len) & (w_occ < 3'd2);

    assign busy_o    = (r_state != S_IDLE);
    assign m_valid_o = w_valid;
    assign m_data_o  = w_valid ? r_fifo[r_rptr] : '0;
    assign m_last_o  = w_valid & w_last_word;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_ready_d  <= 1'b0;
            r_wb_base  <= '0;
            r_row      <= '0;
            r_rd_base  <= '0;
            r_len      <= '0;
            r_issued   <= '0;
            r_popped   <= '0;
            r_inflight <= 1'b0;
            r_count    <= '0;
            r_wptr     <= 1'b0;
            r_rptr     <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_ready_d  <= pe_ready_i;
            r_inflight <= w_issue;

            if (w_capture) begin
                r_wb_base <= wb_base_i;
                r_row     <= '0;
            end else if (r_state == S_WRITE) begin
                r_row <= r_row + ROW_W'(1);
            end

            if (w_rd_accept) begin
                r_rd_base <= rd_base_i;
                r_len     <= rd_len_i;
                r_issued  <= '0;
                r_popped  <= '0;
            end else begin
                if (w_issue) r_issued <= r_issued + LEN_W'(1);
                if (w_pop)   r_popped <= r_popped + LEN_W'(1);
            end

            if (r_inflight) r_wptr <= ~r_wptr;
            if (w_pop)      r_rptr <= ~r_rptr;

            case ({r_inflight, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: ;
            endcase
        end
    end

    // Payload storage carries no reset; outputs are gated by the state/occupancy that does.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            for (int r = 0; r < NUM_ROWS; r++) begin
                r_rows[r] <= pe_result_i[r*W +: W];
            end
        end
        if (r_inflight) begin
            r_fifo[r_wptr] <= o_rdata_i;
        end
    end

    always_comb begin
        w_next    = r_state;
        o_en_o    = 1'b0;
        o_wr_o    = 1'b0;
        o_addr_o  = '0;
        o_wdata_o = '0;
        wb_done_o = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_ready_edge) begin
                    w_next = S_CAPTURE;
                end else if (rd_start_i) begin
                    w_next = S_RD_RUN;
                end
            end
            S_CAPTURE: begin
                w_next = S_WRITE;
            end
            S_WRITE: begin
                o_en_o    = 1'b1;
                o_wr_o    = 1'b1;
                o_addr_o  = wrap_addr(r_wb_base, LEN_W'(r_row));
                o_wdata_o = r_rows[r_row];
                if (r_row == ROW_W'(NUM_ROWS - 1)) begin
                    w_next = S_WB_DONE;
                end
            end
            S_WB_DONE: begin
                wb_done_o = 1'b1;
                w_next    = S_IDLE;
            end
            S_RD_RUN: begin
                if (w_issue) begin
                    o_en_o   = 1'b1;
                    o_addr_o = wrap_addr(r_rd_base, r_issued);
                end
                if (r_len == '0) begin
                    w_next = S_IDLE;
                end else if (w_issue && (r_issued == (r_len - LEN_W'(1)))) begin
                    w_next = S_RD_DRAIN;
                end
            end
            S_RD_DRAIN: begin
                if (w_pop && w_last_word) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_o_writeback_ctrl.sv
// Scoreboard bench for o_writeback_ctrl: stimulus tasks queue expected O_buff writes, reads,
// completion pulses and stream words; a negedge monitor pops and compares them.
module tb_o_writeback_ctrl;

    localparam int DW = 16, NP = 4, NR = 4, DEPTH = 64, AW = 6, W = NP*DW;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR*W-1:0]   pe_result_i;
    logic              pe_ready_i;
    logic [AW-1:0]     wb_base_i;
    logic              wb_done_o;
    logic              rd_start_i;
    logic [AW-1:0]     rd_base_i;
    logic [AW:0]       rd_len_i;
    logic              busy_o;
    logic              o_en_o;
    logic              o_wr_o;
    logic [AW-1:0]     o_addr_o;
    logic [W-1:0]      o_wdata_o;
    logic [W-1:0]      o_rdata_i;
    logic [W-1:0]      m_data_o;
    logic              m_valid_o;
    logic              m_ready_i;
    logic              m_last_o;

    always #5 clk = ~clk;

    o_writeback_ctrl #(
        .DATA_WIDTH(DW), .NUM_PEs_PER_ROW(NP), .NUM_ROWS(NR),
        .O_BUFF_DEPTH(DEPTH), .O_ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .rst(rst),
        .pe_result_i(pe_result_i), .pe_ready_i(pe_ready_i), .wb_base_i(wb_base_i),
        .wb_done_o(wb_done_o),
        .rd_start_i(rd_start_i), .rd_base_i(rd_base_i), .rd_len_i(rd_len_i),
        .busy_o(busy_o),
        .o_en_o(o_en_o), .o_wr_o(o_wr_o), .o_addr_o(o_addr_o), .o_wdata_o(o_wdata_o),
        .o_rdata_i(o_rdata_i),
        .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_last_o(m_last_o)
    );

    typedef struct { logic [AW-1:0] a; logic [W-1:0] d; } wr_t;
    typedef struct { logic [W-1:0] d; logic l; } st_t;

    wr_t           wq[$];
    logic [AW-1:0] rq[$];
    st_t           sq[$];
    int            exp_done  = 0;
    int            done_seen = 0;
    int            total = 0;
    int            bad   = 0;
    logic [W-1:0]  mem     [DEPTH];
    logic [W-1:0]  exp_mem [DEPTH];

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic flag(input string nm, input logic [W-1:0] act);
        total++;
        bad++;
        $display("FAIL %s actual=%0h required=none", nm, act);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // O_buff model: one-cycle read latency.
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 64'hA5A5_0000_0000_0000 | 64'(i);
        forever begin
            @(posedge clk);
            if (o_en_o && o_wr_o)  mem[o_addr_o] <= o_wdata_o;
            if (o_en_o && !o_wr_o) o_rdata_i     <= mem[o_addr_o];
        end
    end

    // Monitor
    initial begin
        wr_t          we;
        st_t          se;
        logic [AW-1:0] ra;
        logic         stall_prev;
        logic [W-1:0] stall_data;
        stall_prev = 1'b0;
        stall_data = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (o_en_o && o_wr_o) begin
                    if (wq.size() == 0) flag("wr_unexpected", 64'(o_addr_o));
                    else begin
                        we = wq.pop_front();
                        chk("wr_addr", 64'(o_addr_o), 64'(we.a));
                        chk("wr_data", o_wdata_o, we.d);
                    end
                end
                if (o_en_o && !o_wr_o) begin
                    if (rq.size() == 0) flag("rd_unexpected", 64'(o_addr_o));
                    else begin
                        ra = rq.pop_front();
                        chk("rd_addr", 64'(o_addr_o), 64'(ra));
                    end
                end
                if (wb_done_o) begin
                    done_seen++;
                    if (exp_done == 0) flag("done_unexpected", 64'(done_seen));
                    else exp_done--;
                end
                if (stall_prev && m_valid_o) chk("stall_stable", m_data_o, stall_data);
                if (m_valid_o && m_ready_i) begin
                    if (sq.size() == 0) flag("stream_unexpected", m_data_o);
                    else begin
                        se = sq.pop_front();
                        chk("stream_data", m_data_o, se.d);
                        chk("stream_last", 64'(m_last_o), 64'(se.l));
                    end
                end
                stall_prev = m_valid_o && !m_ready_i;
                stall_data = m_data_o;
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    // Queue nexp rows of a writeback, raise ready and advance into CAPTURE.
    task automatic start_wb(input logic [AW-1:0] base, input logic [W-1:0] d0,
                            input int nexp, input bit expdone);
        for (int r = 0; r < NR; r++) begin
            pe_result_i[r*W +: W] = d0 + 64'(r);
            if (r < nexp) begin
                wq.push_back('{a: AW'((int'(base) + r) % DEPTH), d: d0 + 64'(r)});
                exp_mem[(int'(base) + r) % DEPTH] = d0 + 64'(r);
            end
        end
        if (expdone) exp_done++;
        wb_base_i  = base;
        pe_ready_i = 1'b1;
        tick();
    endtask

    task automatic start_rd(input logic [AW-1:0] base, input int len, input int nrd, input bit stream);
        for (int i = 0; i < nrd; i++) rq.push_back(AW'((int'(base) + i) % DEPTH));
        if (stream) begin
            for (int i = 0; i < len; i++)
                sq.push_back('{d: exp_mem[(int'(base) + i) % DEPTH], l: (i == len - 1)});
        end
        rd_base_i  = base;
        rd_len_i   = (AW+1)'(len);
        rd_start_i = 1'b1;
        tick();
        rd_start_i = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int maxc);
        int n;
        n = 0;
        while (busy_o && n < maxc) begin
            tick();
            n++;
        end
        chk(nm, 64'(busy_o), 64'd0);
    endtask

    initial begin
        logic [6:0] pat;
        int         ds0, cnt_b, cnt_e, cnt_v, n;
        logic       eb, ee, ed;

        for (int i = 0; i < DEPTH; i++) exp_mem[i] = 64'hA5A5_0000_0000_0000 | 64'(i);
        rst = 1'b0;
        pe_result_i = '0; pe_ready_i = 1'b0; wb_base_i = '0;
        rd_start_i = 1'b0; rd_base_i = '0; rd_len_i = '0; m_ready_i = 1'b0;

        #2;
        chk("rst_busy",  64'(busy_o),    64'd0);
        chk("rst_en",    64'(o_en_o),    64'd0);
        chk("rst_valid", 64'(m_valid_o), 64'd0);
        chk("rst_done",  64'(wb_done_o), 64'd0);
        chk("rst_addr",  64'(o_addr_o),  64'd0);
        chk("rst_mdata", m_data_o,       64'd0);
        repeat (3) tick();
        rst = 1'b1;
        tick();

        // Writeback with cycle-accurate timing
        start_wb(6'd5, 64'h0001_0002_0003_0004, NR, 1'b1);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            eb = (c >= 1) && (c <= 6);
            ee = (c >= 2) && (c <= 5);
            ed = (c == 6);
            chk("t1_busy", 64'(busy_o),    64'(eb));
            chk("t1_en",   64'(o_en_o),    64'(ee));
            chk("t1_wr",   64'(o_wr_o),    64'(ee));
            chk("t1_done", 64'(wb_done_o), 64'(ed));
            tick();
        end
        pe_ready_i = 1'b0;
        tick();

        // Address wrap, then ready held high
        ds0 = done_seen;
        start_wb(6'd62, 64'h1111_2222_3333_4440, NR, 1'b1);
        repeat (19) tick();
        chk("level_one_wb", 64'(done_seen - ds0), 64'd1);
        pe_ready_i = 1'b0;
        tick();

        // Readout with backpressure
        pat = 7'b1011001;
        rq.push_back(6'd5); rq.push_back(6'd6); rq.push_back(6'd7); rq.push_back(6'd8);
        sq.push_back('{d: 64'h0001_0002_0003_0004, l: 1'b0});
        sq.push_back('{d: 64'h0001_0002_0003_0005, l: 1'b0});
        sq.push_back('{d: 64'h0001_0002_0003_0006, l: 1'b0});
        sq.push_back('{d: 64'h0001_0002_0003_0007, l: 1'b1});
        start_rd(6'd5, 4, 0, 1'b0);
        n = 0;
        while (!m_valid_o && n < 10) begin tick(); n++; end
        chk("rd_first_valid", 64'(m_valid_o), 64'd1);
        for (int p = 0; p < 7; p++) begin
            m_ready_i = pat[p];
            tick();
        end
        m_ready_i = 1'b1;
        wait_idle("rd_idle", 20);
        chk("rd_all_delivered", 64'(sq.size()), 64'd0);

        // Collisions: rd_start with the ready edge, and during WRITE
        rd_base_i = 6'd0; rd_len_i = 7'd4; rd_start_i = 1'b1;
        start_wb(6'd20, 64'h2000_0000_0000_0010, NR, 1'b1);
        rd_start_i = 1'b0;
        tick();
        tick();
        rd_start_i = 1'b1;
        tick();
        rd_start_i = 1'b0;
        wait_idle("col_idle", 20);
        repeat (3) tick();
        chk("col_busy",  64'(busy_o),    64'd0);
        chk("col_valid", 64'(m_valid_o), 64'd0);
        pe_ready_i = 1'b0;
        tick();

        // rd_len = 0
        rd_base_i = 6'd3; rd_len_i = 7'd0; rd_start_i = 1'b1;
        cnt_b = 0; cnt_e = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (busy_o) cnt_b++;
            if (o_en_o) cnt_e++;
            tick();
            rd_start_i = 1'b0;
        end
        chk("len0_busy_cycles", 64'(cnt_b), 64'd1);
        chk("len0_en_cycles",   64'(cnt_e), 64'd0);

        // Full-depth wrapping read at full rate
        m_ready_i = 1'b1;
        start_rd(6'd60, 64, 64, 1'b1);
        n = 0;
        while (!m_valid_o && n < 10) begin tick(); n++; end
        cnt_v = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (m_valid_o && m_ready_i) cnt_v++;
            tick();
        end
        chk("full_consecutive", 64'(cnt_v), 64'd64);
        wait_idle("full_idle", 10);

        // Async reset during WRITE row 2
        start_wb(6'd40, 64'h4000_0000_0000_0000, 2, 1'b0);
        repeat (3) tick();
        rst = 1'b0;
        #1;
        chk("rstw_en",    64'(o_en_o),    64'd0);
        chk("rstw_wr",    64'(o_wr_o),    64'd0);
        chk("rstw_addr",  64'(o_addr_o),  64'd0);
        chk("rstw_wdata", o_wdata_o,      64'd0);
        chk("rstw_busy",  64'(busy_o),    64'd0);
        chk("rstw_done",  64'(wb_done_o), 64'd0);
        pe_ready_i = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        start_wb(6'd30, 64'h3000_0000_0000_0000, NR, 1'b1);
        wait_idle("rec1_idle", 20);
        pe_ready_i = 1'b0;
        tick();

        // Async reset in RD_DRAIN with a full FIFO
        m_ready_i = 1'b0;
        start_rd(6'd5, 2, 2, 1'b0);
        repeat (3) tick();
        chk("drain_valid", 64'(m_valid_o), 64'd1);
        chk("drain_busy",  64'(busy_o),    64'd1);
        rst = 1'b0;
        #1;
        chk("rstd_valid", 64'(m_valid_o), 64'd0);
        chk("rstd_data",  m_data_o,       64'd0);
        chk("rstd_last",  64'(m_last_o),  64'd0);
        chk("rstd_busy",  64'(busy_o),    64'd0);
        chk("rstd_en",    64'(o_en_o),    64'd0);
        repeat (2) tick();
        rst = 1'b1;
        m_ready_i = 1'b1;
        tick();
        start_wb(6'd50, 64'h5000_0000_0000_0000, NR, 1'b1);
        wait_idle("rec2_idle", 20);
        pe_ready_i = 1'b0;
        repeat (3) tick();

        chk("end_wq_empty",  64'(wq.size()), 64'd0);
        chk("end_rq_empty",  64'(rq.size()), 64'd0);
        chk("end_sq_empty",  64'(sq.size()), 64'd0);
        chk("end_done_left", 64'(exp_done),  64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
